// File: rtl/inst_encoder_if.sv
// Field-bundle handshake and instruction-memory write bus for inst_encoder.
// The master drives decoded fields; the slave (encoder) drives the write port and status.
interface inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic               Clear;
  logic               InValid;
  logic               InReady;
  logic [1:0]         Kind;
  logic [4:0]         Rd;
  logic [4:0]         Rs1;
  logic [4:0]         Rs2;
  logic [3:0]         Funct;
  logic signed [31:0] Imm;
  logic               WrEn;
  logic [ADDR_W-1:0]  WrAddr;
  logic [31:0]        WrData;
  logic               Full;
  logic               Err;
  logic [1:0]         ErrCode;

  modport master (
    output Clear, InValid, Kind, Rd, Rs1, Rs2, Funct, Imm,
    input  InReady, WrEn, WrAddr, WrData, Full, Err, ErrCode
  );

  modport slave (
    input  Clear, InValid, Kind, Rd, Rs1, Rs2, Funct, Imm,
    output InReady, WrEn, WrAddr, WrData, Full, Err, ErrCode
  );
endinterface

// File: rtl/inst_encoder.sv
// Two-stage RV32I encoder (R/lw/sw/beq) that streams words into instruction memory
// at consecutive addresses; out-of-range or misaligned immediates are dropped and flagged.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus
);
  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = '1;

  // 00 ok, 01 out of range, 10 misaligned; range wins when both fail
  function automatic logic [1:0] imm_check(input logic [1:0] kind,
                                           input logic signed [31:0] imm);
    logic [1:0] code;
    code = 2'b00;
    case (kind)
      2'b01, 2'b10: if (imm < -32'sd2048 || imm > 32'sd2047) code = 2'b01;
      2'b11: begin
        if (imm < -32'sd4096 || imm > 32'sd4094) code = 2'b01;
        else if (imm[0])                          code = 2'b10;
      end
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  function automatic logic [31:0] encode(input logic [1:0] kind, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [3:0] funct, input logic [12:0] imm);
    logic [31:0] w;
    case (kind)
      2'b00:   w = {(funct[3] ? 7'b0100000 : 7'b0000000), rs2, rs1, funct[2:0], rd, 7'b0110011};
      2'b01:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      2'b10:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      default: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endcase
    return w;
  endfunction

  logic              r_vld_p1;
  logic [1:0]        r_kind_p1;
  logic [4:0]        r_rd_p1;
  logic [4:0]        r_rs1_p1;
  logic [4:0]        r_rs2_p1;
  logic [3:0]        r_funct_p1;
  logic [12:0]       r_imm_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_full;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_wr_en_p2;
  logic [ADDR_W-1:0] r_wr_addr_p2;
  logic [31:0]       r_wr_data_p2;

  logic              w_xfer;
  logic [1:0]        w_code;
  logic              w_accept;
  logic              w_reject;

  // Clear blocks capture even when a bundle is offered in the same cycle
  assign w_xfer   = bus.InValid && !r_full && !bus.Clear;
  assign w_code   = imm_check(bus.Kind, bus.Imm);
  assign w_accept = w_xfer && (w_code == 2'b00);
  assign w_reject = w_xfer && (w_code != 2'b00);

  // Stage 1: field and address capture
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind_p1  <= bus.Kind;
      r_rd_p1    <= bus.Rd;
      r_rs1_p1   <= bus.Rs1;
      r_rs2_p1   <= bus.Rs2;
      r_funct_p1 <= bus.Funct;
      r_imm_p1   <= bus.Imm[12:0];
      r_addr_p1  <= r_next_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_next_addr  <= LP_BASE;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_wr_en_p2   <= 1'b0;
      r_wr_addr_p2 <= '0;
      r_wr_data_p2 <= '0;
    end else if (bus.Clear) begin
      r_vld_p1    <= 1'b0;
      r_next_addr <= LP_BASE;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
      r_wr_en_p2  <= 1'b0;
    end else begin
      r_vld_p1   <= w_accept;
      // Stage 2: encode and present the write
      r_wr_en_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_wr_addr_p2 <= r_addr_p1;
        r_wr_data_p2 <= encode(r_kind_p1, r_rd_p1, r_rs1_p1, r_rs2_p1, r_funct_p1, r_imm_p1);
      end
      // The last address saturates the counter instead of wrapping
      if (w_accept) begin
        if (r_next_addr == LP_LAST) r_full <= 1'b1;
        else                        r_next_addr <= r_next_addr + 1'b1;
      end
      if (w_reject) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
    end
  end

  assign bus.InReady = !r_full;
  assign bus.WrEn    = r_wr_en_p2;
  assign bus.WrAddr  = r_wr_addr_p2;
  assign bus.WrData  = r_wr_data_p2;
  assign bus.Full    = r_full;
  assign bus.Err     = r_err;
  assign bus.ErrCode = r_err_code;
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: unit A (ADDR_W=8, BASE_ADDR=0) and unit B (ADDR_W=3, BASE_ADDR=4)
// share clock, reset and field wires; sel routes InValid/Clear to one of them.
module tb_inst_encoder;
  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic valid = 1'b0;
  logic clr = 1'b0;
  logic [1:0] kind = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [3:0] funct = '0;
  logic signed [31:0] imm = '0;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_encoder_if #(.ADDR_W(8)) ba ();
  inst_encoder_if #(.ADDR_W(3)) bb ();

  assign ba.InValid = valid & ~sel;
  assign ba.Clear   = clr & ~sel;
  assign ba.Kind = kind; assign ba.Rd = rd; assign ba.Rs1 = rs1; assign ba.Rs2 = rs2;
  assign ba.Funct = funct; assign ba.Imm = imm;
  assign bb.InValid = valid & sel;
  assign bb.Clear   = clr & sel;
  assign bb.Kind = kind; assign bb.Rd = rd; assign bb.Rs1 = rs1; assign bb.Rs2 = rs2;
  assign bb.Funct = funct; assign bb.Imm = imm;

  inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  inst_encoder #(.ADDR_W(3), .BASE_ADDR(4)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Offer one bundle for one edge; optionally queue the write it must produce two edges later.
  task automatic send(input bit s, input logic [1:0] k, input logic [4:0] d, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [3:0] f, input logic signed [31:0] im,
                      input bit expw, input int unsigned ea, input logic [31:0] ed);
    exp_t e;
    sel = s; kind = k; rd = d; rs1 = r1; rs2 = r2; funct = f; imm = im; valid = 1'b1;
    if (expw) begin
      e.addr = ea; e.data = ed; e.cyc = cyc + 2;
      if (s) qb.push_back(e);
      else   qa.push_back(e);
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] full_words [4] = '{32'h00002083, 32'h00102083, 32'h00202083, 32'h00302083};

  initial begin
    exp_t e;
    fork
      forever begin
        @(negedge clk);
        if (ba.WrEn) begin
          if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_wr: got write addr %0h data %0h expected none", ba.WrAddr, ba.WrData);
          end else begin
            e = qa.pop_front();
            chk("a_wraddr", 32'(ba.WrAddr), e.addr);
            chk("a_wrdata", ba.WrData, e.data);
            chk("a_latency", cyc, e.cyc);
          end
        end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
          e = qa.pop_front();
          total++; bad++;
          $display("FAIL a_missing_wr: got no write expected addr %0h data %0h", e.addr, e.data);
        end
        if (bb.WrEn) begin
          if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_wr: got write addr %0h data %0h expected none", bb.WrAddr, bb.WrData);
          end else begin
            e = qb.pop_front();
            chk("b_wraddr", 32'(bb.WrAddr), e.addr);
            chk("b_wrdata", bb.WrData, e.data);
            chk("b_latency", cyc, e.cyc);
          end
        end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
          e = qb.pop_front();
          total++; bad++;
          $display("FAIL b_missing_wr: got no write expected addr %0h data %0h", e.addr, e.data);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_inready", 32'(ba.InReady), 1);
    chk("rst_wren", 32'(ba.WrEn), 0);
    chk("rst_wraddr", 32'(ba.WrAddr), 0);
    chk("rst_wrdata", ba.WrData, 0);
    chk("rst_full", 32'(ba.Full), 0);
    chk("rst_err", 32'(ba.Err), 0);
    chk("rst_errcode", 32'(ba.ErrCode), 0);
    chk("rst_b_inready", 32'(bb.InReady), 1);
    rst = 1'b0;
    idle(1);

    // Encoding of each kind, back to back
    send(0, 2'b01, 5, 2, 0, 4'h0, -4, 1, 0, 32'hFFC12283);
    send(0, 2'b10, 0, 2, 6, 4'h0,  8, 1, 1, 32'h00612423);
    send(0, 2'b11, 0, 1, 2, 4'h0, -8, 1, 2, 32'hFE208CE3);
    send(0, 2'b00, 3, 1, 2, 4'h8,  0, 1, 3, 32'h402081B3);
    idle(3);

    // Rejections and boundary immediates
    send(0, 2'b01, 5, 2, 0, 4'h0, 2048, 0, 0, 0);
    chk("rej_lw_err", 32'(ba.Err), 1);
    chk("rej_lw_code", 32'(ba.ErrCode), 1);
    send(0, 2'b11, 0, 1, 2, 4'h0, 6, 1, 4, 32'h00208363);
    send(0, 2'b11, 0, 1, 2, 4'h0, 5, 0, 0, 0);
    chk("rej_beq5_err", 32'(ba.Err), 1);
    chk("rej_beq5_code", 32'(ba.ErrCode), 2);
    send(0, 2'b11, 0, 1, 2, 4'h0, 5001, 0, 0, 0);
    chk("rej_beq5001_code", 32'(ba.ErrCode), 1);
    send(0, 2'b01, 5, 2, 0, 4'h0, -2048, 1, 5, 32'h80012283);
    send(0, 2'b11, 0, 0, 0, 4'h0, 4094, 1, 6, 32'h7E000FE3);
    chk("err_sticky", 32'(ba.Err), 1);
    idle(3);

    // Clear collides with a transfer while another word sits in stage 1
    sel = 0; kind = 2'b00; rd = 7; rs1 = 7; rs2 = 7; funct = 4'h0; imm = 0; valid = 1'b1;
    @(posedge clk); #1;
    rd = 9; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; valid = 1'b0;
    chk("clr_err", 32'(ba.Err), 0);
    chk("clr_errcode", 32'(ba.ErrCode), 0);
    chk("clr_inready", 32'(ba.InReady), 1);
    idle(3);
    send(0, 2'b00, 1, 2, 3, 4'h0, 0, 1, 0, 32'h003100B3);
    idle(3);

    // Fill unit B (addresses 4..7), then hold a fifth bundle while full
    for (int k = 0; k < 4; k++)
      send(1, 2'b01, 1, 0, 0, 4'h0, k, 1, 32'(4 + k), full_words[k]);
    chk("full_set", 32'(bb.Full), 1);
    chk("full_inready", 32'(bb.InReady), 0);
    sel = 1; kind = 2'b01; rd = 1; rs1 = 0; imm = 0; valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    valid = 1'b0;
    chk("full_hold", 32'(bb.Full), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("full_clr", 32'(bb.Full), 0);
    chk("full_clr_ready", 32'(bb.InReady), 1);
    send(1, 2'b01, 2, 0, 0, 4'h0, 0, 1, 4, 32'h00002103);
    idle(3);

    // Asynchronous reset in the middle of a three-word burst
    send(1, 2'b01, 1, 0, 0, 4'h0, 0, 1, 5, 32'h00002083);
    send(1, 2'b01, 1, 0, 0, 4'h0, 1, 0, 0, 0);
    sel = 1; imm = 2; valid = 1'b1;
    #6;
    rst = 1'b1;
    #1;
    valid = 1'b0;
    chk("arst_wren", 32'(bb.WrEn), 0);
    chk("arst_wraddr", 32'(bb.WrAddr), 0);
    chk("arst_wrdata", bb.WrData, 0);
    chk("arst_inready", 32'(bb.InReady), 1);
    chk("arst_a_wrdata", ba.WrData, 0);
    #1;
    rst = 1'b0;
    send(1, 2'b01, 3, 0, 0, 4'h0, 0, 1, 4, 32'h00002183);
    idle(5);
    chk("drain", 32'(qa.size() + qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
